// File: rtl/hls_deadlock_reporter_if.sv
// rtl/hls_deadlock_reporter_if.sv - report port of the HLS deadlock reporter
// Carries the frozen diagnostic record over a valid/ready handshake.
interface hls_deadlock_reporter_if #(
  parameter int NUM_MON = 4,
  parameter int SNAP_W  = 3
);
  logic               report_valid;
  logic               report_ready;
  logic [NUM_MON-1:0] report_mon;
  logic [SNAP_W-1:0]  report_snap;
  logic [31:0]        report_cycles;

  modport master (
    output report_valid,
    output report_mon,
    output report_snap,
    output report_cycles,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_mon,
    input  report_snap,
    input  report_cycles,
    output report_ready
  );
endinterface

// File: rtl/hls_deadlock_reporter.sv
// rtl/hls_deadlock_reporter.sv - persistence filter and frozen report for HLS deadlock monitors
// Confirms a deadlock after HOLD_CYCLES of continuous any-block, then keeps a sticky flag until clear.
module hls_deadlock_reporter #(
  parameter int NUM_MON     = 4,
  parameter int SNAP_W      = 3,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_MON-1:0]      mon_block,
  input  logic [SNAP_W-1:0]       snap_in,
  input  logic                    clear,
  hls_deadlock_reporter_if.master rpt,
  output logic                    deadlock
);
  localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam bit               SINGLE   = (HOLD_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, ARMED, REPORT, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [31:0]        cyc_q, cyc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        start_stamp_q, start_stamp_d;
  logic               report_valid_q, report_valid_d;
  logic [NUM_MON-1:0] report_mon_q, report_mon_d;
  logic [SNAP_W-1:0]  report_snap_q, report_snap_d;
  logic [31:0]        report_cycles_q, report_cycles_d;
  logic               deadlock_q, deadlock_d;
  logic               any;
  logic               confirm;

  assign any = |mon_block;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cyc_q           <= '0;
      cnt_q           <= '0;
      start_stamp_q   <= '0;
      report_valid_q  <= 1'b0;
      report_mon_q    <= '0;
      report_snap_q   <= '0;
      report_cycles_q <= '0;
      deadlock_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cyc_q           <= cyc_d;
      cnt_q           <= cnt_d;
      start_stamp_q   <= start_stamp_d;
      report_valid_q  <= report_valid_d;
      report_mon_q    <= report_mon_d;
      report_snap_q   <= report_snap_d;
      report_cycles_q <= report_cycles_d;
      deadlock_q      <= deadlock_d;
    end
  end

  // A clear during ARMED beats the confirming edge; in REPORT the record must drain first.
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = SINGLE ? REPORT : ARMED;
      ARMED: begin
        if (clear || !any)          state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = REPORT;
      end
      REPORT:  if (rpt.report_ready) state_d = LOCKED;
      LOCKED:  if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    confirm         = (state_q != REPORT) && (state_d == REPORT);
    cyc_d           = cyc_q + 32'd1;
    cnt_d           = '0;
    start_stamp_d   = start_stamp_q;
    report_valid_d  = (state_d == REPORT);
    deadlock_d      = (state_d == REPORT) || (state_d == LOCKED);
    report_mon_d    = report_mon_q;
    report_snap_d   = report_snap_q;
    report_cycles_d = report_cycles_q;

    if ((state_q == IDLE) && (state_d == ARMED)) begin
      cnt_d         = CNT_W'(1);
      start_stamp_d = cyc_q;
    end else if ((state_q == ARMED) && (state_d == ARMED)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (confirm) begin
      report_mon_d    = mon_block;
      report_snap_d   = snap_in;
      report_cycles_d = SINGLE ? cyc_q : start_stamp_q;
    end
  end

  assign rpt.report_valid  = report_valid_q;
  assign rpt.report_mon    = report_mon_q;
  assign rpt.report_snap   = report_snap_q;
  assign rpt.report_cycles = report_cycles_q;
  assign deadlock          = deadlock_q;
endmodule

// File: doc/hls_deadlock_reporter.md
# hls_deadlock_reporter

Sink-side companion to the per-instance HLS deadlock monitors. It collects the `block` outputs of up to NUM_MON monitors and confirms a deadlock only when some monitor output stays high for HOLD_CYCLES consecutive cycles. On confirmation it freezes a diagnostic record (which monitors fired, a stream-state snapshot, a cycle timestamp) and presents it on a valid/ready report port. It then holds a sticky `deadlock` flag until software or the testbench clears it.

## Interface
- NUM_MON, 4: number of monitor `block` inputs (≥1).
- SNAP_W, 3: width of the snapshot bus, e.g. axis block signals (≥1).
- HOLD_CYCLES, 16: consecutive cycles of any-block required to confirm (≥1).
- CNT_W, $clog2(HOLD_CYCLES+1): persistence counter width (derived, not overridden).

- clock  in  1  clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- mon_block  in  NUM_MON  block outputs of the monitors, one bit per monitor.
- snap_in  in  SNAP_W  stream/instance state sampled into the report.
- clear  in  1  single-cycle request to re-arm after a report.
- report_valid  out  1  report record available.
- report_ready  in  1  consumer accepts the record.
- report_mon  out  NUM_MON  mon_block value on the confirming cycle.
- report_snap  out  SNAP_W  snap_in value on the confirming cycle.
- report_cycles  out  32  cycle-counter value on the first cycle of the confirmed window.
- deadlock  out  1  sticky confirmed-deadlock flag.

## Operation
- Free-running 32-bit cycle counter `cyc`. It reads 0 in the first cycle after reset deasserts, increments every cycle, and wraps from 2^32-1 to 0 with no flag.
- `any = |mon_block`.
- FSM states: IDLE, ARMED, REPORT, LOCKED. All outputs are registered.
- IDLE:
  - cnt = 0.
  - If `any` and HOLD_CYCLES==1, go to REPORT.
  - Else if `any`, go to ARMED with cnt←1 and start_stamp←cyc.
- ARMED:
  - If `!any`, go to IDLE with cnt←0. This filters glitches; there is no partial credit.
  - Else if cnt==HOLD_CYCLES-1, go to REPORT.
  - Else cnt←cnt+1.
  - If `clear`, go to IDLE. This has priority over counting.
- Confirmation is any transition into REPORT. On that edge:
  - report_mon←mon_block and report_snap←snap_in.
  - report_cycles←start_stamp, or ←cyc when HOLD_CYCLES==1.
  - deadlock←1.
- Different monitors may take turns being high inside the window. Only `any` must be continuous.
- REPORT:
  - report_valid=1. All report_* fields hold stable until the handshake.
  - report_valid&report_ready → LOCKED, with report_valid←0 next cycle.
  - `clear` is ignored in REPORT; the record must be consumed first.
- LOCKED:
  - deadlock stays 1 and mon_block is ignored.
  - report_* fields keep their last values.
  - `clear` → IDLE with deadlock←0.
- `clear` in IDLE has no effect.
- Reset mid-operation from any state returns to IDLE in the next cycle. All outputs and internal registers go to 0, including cyc, cnt and start_stamp.

## Timing
- Reset values: report_valid=0, report_mon=0, report_snap=0, report_cycles=0, deadlock=0.
- `any` high in cycles t … t+H-1 (H=HOLD_CYCLES) gives report_valid=1 and deadlock=1 first in cycle t+H, with report_cycles = cyc(t).
  - For H=1: `any` in cycle t gives valid in cycle t+1.
- `any` low in any cycle of the window means no report. A new window may start in the very next cycle where `any` is high.
- Handshake: standard valid/ready.
  - Valid never drops without ready.
  - ready may be held high in advance; the transfer completes in the first valid cycle.
- clear in LOCKED at cycle c: deadlock=0 in c+1. A new window can begin sampling in c+1, so the earliest next report_valid is at c+1+H.
- Simultaneous clear with the confirming edge in ARMED: clear wins, and the state returns to IDLE with no report.

## Test plan
- Persistence: H=16, mon_block=4'b0010 for 16 cycles starting at cyc=100, snap_in=3'b101. Required: report_valid rises at cyc=116, report_mon=0010, report_snap=101, report_cycles=100, deadlock=1.
- Glitch filter: H=16, mon_block high 15 cycles, low 1, high 15. Required: no report_valid and deadlock stays 0. Then 16 high cycles → report.
- Rotating monitors: bit0 for 8 cycles, then bit3 for 8 cycles, contiguous. Required: report at cycle 16 with report_mon=4'b1000.
- Backpressure: report_ready=0 for 20 cycles after valid, with mon_block and snap_in toggling. Required: fields stable and valid held. ready=1 → valid 0 next cycle; deadlock stays 1.
- Clear/re-arm: in LOCKED pulse clear with mon_block held at 1. Required: deadlock 0 next cycle, new report exactly H+1 cycles after the clear cycle. Clear pulsed in REPORT is ignored.
- Reset mid-window and H=1 build: reset asserted in ARMED gives all outputs 0 with no report. With H=1, a single-cycle block gives report_valid one cycle later, with report_cycles = cyc of the block cycle.
